// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous buffer of fetched {pc, instr} entries with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  fetch_entry_t                 i_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty,
  output fetch_entry_t                 o_head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic w_wr_en, w_rd_en;
  assign w_wr_en = i_push & ~i_flush;
  assign w_rd_en = i_pop & ~i_flush & (r_cnt != '0);
  assign o_count = r_cnt;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_head  = r_mem[r_rd];
  // pointers and occupancy; a flush empties the buffer ahead of any push that cycle
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr_en) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
      if (w_rd_en) r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(w_wr_en) - CW'(w_rd_en);
    end
  end
  // storage needs no reset: entries are only observed once written
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: IF-stage PC sequencer driving a 1-cycle imem into a small instruction buffer
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [31:0] r_pc, r_inflight_pc;
  logic r_inflight, r_kill;
  logic [31:0] w_redirect_pc;
  logic [CW-1:0] w_count;
  logic [CW:0] w_occ;
  logic w_full, w_empty, w_pop, w_push, w_issue;
  fetch_entry_t w_head;
  assign w_redirect_pc = redirect_pc & ~32'h3;
  assign w_pop   = if_valid & if_ready;
  assign w_push  = r_inflight & ~r_kill;
  assign w_occ   = (CW+1)'(r_inflight) + (CW+1)'(w_count) - (CW+1)'(w_pop);
  assign w_issue = fetch_en & ~redirect_vld & (w_occ < (CW+1)'(BUF_DEPTH));
  assign imem_en   = w_issue;
  assign imem_addr = r_pc;
  assign if_valid  = ~w_empty;
  assign if_pc     = w_empty ? '0 : w_head.pc;
  assign if_instr  = w_empty ? '0 : w_head.instr;
  // PC sequencing and in-flight tracking; a redirect always wins over sequential fetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_kill        <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= redirect_vld;
      if (w_issue) r_inflight_pc <= r_pc;
      r_pc <= redirect_vld ? w_redirect_pc : w_issue ? r_pc + INSTR_BYTES : r_pc;
    end
  end
  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_vld),
    .i_data  ('{pc: r_inflight_pc, instr: imem_rdata}),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !redirect_vld && w_full));
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scoreboard bench for the fetch controller
module tb_fetch_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0, redirect_vld = 1'b0, if_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_en, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;
  logic [31:0] imem_rdata = '0;
  logic        fetch_en1 = 1'b0, if_ready1 = 1'b0;
  logic        imem_en1, if_valid1;
  logic [31:0] imem_addr1, if_pc1, if_instr1;
  logic [31:0] imem_rdata1 = '0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int n_cmp = 0;
  int n_fail = 0;

  fetch_controller u0 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr)
  );
  fetch_controller #(.RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en1), .redirect_vld(1'b0),
    .redirect_pc(32'h0), .imem_en(imem_en1), .imem_addr(imem_addr1),
    .imem_rdata(imem_rdata1), .if_valid(if_valid1), .if_ready(if_ready1),
    .if_pc(if_pc1), .if_instr(if_instr1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= f(imem_addr);
    if (imem_en1) imem_rdata1 <= f(imem_addr1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb();
    logic [31:0] e;
    if (rst_n && if_valid && if_ready && !redirect_vld) begin
      n_cmp++;
      assert (q0.size() != 0) else begin
        n_fail++;
        $error("FAIL sb0_extra: observed pc %h expected no delivery", if_pc);
      end
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("sb0_pc", if_pc, e);
        chk("sb0_instr", if_instr, f(e));
      end
    end
    if (rst_n && if_valid1 && if_ready1) begin
      n_cmp++;
      assert (q1.size() != 0) else begin
        n_fail++;
        $error("FAIL sb1_extra: observed pc %h expected no delivery", if_pc1);
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("sb1_pc", if_pc1, e);
        chk("sb1_instr", if_instr1, f(e));
      end
    end
  endtask

  task automatic nxt();
    #1;
    sb();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    if_ready = 1'b0;
    fetch_en1 = 1'b0;
    if_ready1 = 1'b0;
    redirect_vld = 1'b1;
    redirect_pc = 32'h300;
    nxt();
    nxt();
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_en", 32'(imem_en), 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_valid1", 32'(if_valid1), 0);
    redirect_vld = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    // streaming from reset, reset overriding a redirect
    do_reset();
    rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
    for (int i = 0; i < 6; i++) q0.push_back(32'(i * 4));
    #1;
    chk("t1_en0", 32'(imem_en), 1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_v0", 32'(if_valid), 0);
    nxt(); #1;
    chk("t1_addr1", imem_addr, 32'h4);
    chk("t1_v1", 32'(if_valid), 0);
    nxt(); #1;
    chk("t1_addr2", imem_addr, 32'h8);
    chk("t1_v2", 32'(if_valid), 1);
    chk("t1_pc2", if_pc, 32'h0);
    nxt(); #1;
    chk("t1_pc3", if_pc, 32'h4);
    nxt(); nxt(); nxt();
    fetch_en = 1'b0;
    nxt(); nxt(); nxt(); #1;
    chk("t1_idle", 32'(if_valid), 0);
    chk("t1_drained", q0.size(), 0);
    // backpressure: buffer holds two, then resumes with no gap
    do_reset();
    rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b0;
    repeat (4) nxt();
    #1;
    chk("t2_en_stall", 32'(imem_en), 0);
    chk("t2_head", if_pc, 32'h0);
    nxt();
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(32'(i * 4));
    #1;
    chk("t2_r0", if_pc, 32'h0);
    nxt(); #1;
    chk("t2_r1", if_pc, 32'h4);
    nxt();
    fetch_en = 1'b0;
    #1;
    chk("t2_r2_v", 32'(if_valid), 1);
    chk("t2_r2", if_pc, 32'h8);
    nxt(); #1;
    chk("t2_r3", if_pc, 32'hC);
    nxt(); #1;
    chk("t2_drained", q0.size(), 0);
    // redirect with a word in flight and an entry buffered
    do_reset();
    rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b0;
    nxt(); nxt();
    redirect_vld = 1'b1; redirect_pc = 32'h100;
    #1;
    chk("t3_no_issue", 32'(imem_en), 0);
    nxt();
    redirect_vld = 1'b0;
    #1;
    chk("t3_r1_en", 32'(imem_en), 1);
    chk("t3_r1_addr", imem_addr, 32'h100);
    chk("t3_flushed", 32'(if_valid), 0);
    nxt(); #1;
    chk("t3_r2_v", 32'(if_valid), 0);
    nxt();
    if_ready = 1'b1; fetch_en = 1'b0;
    q0.push_back(32'h100); q0.push_back(32'h104);
    #1;
    chk("t3_r3_v", 32'(if_valid), 1);
    chk("t3_r3_pc", if_pc, 32'h100);
    nxt(); #1;
    chk("t3_r4_pc", if_pc, 32'h104);
    nxt(); #1;
    chk("t3_drained", q0.size(), 0);
    // misaligned target, then back-to-back redirects
    redirect_vld = 1'b1; redirect_pc = 32'h203; fetch_en = 1'b1; if_ready = 1'b1;
    q0.push_back(32'h200);
    #1;
    chk("t4_no_issue", 32'(imem_en), 0);
    nxt();
    redirect_vld = 1'b0;
    #1;
    chk("t4_align", imem_addr, 32'h200);
    nxt(); nxt(); #1;
    chk("t4_pc200", if_pc, 32'h200);
    nxt();
    redirect_vld = 1'b1; redirect_pc = 32'h40;
    nxt();
    redirect_pc = 32'h80;
    #1;
    chk("t4_b2b_no_issue", 32'(imem_en), 0);
    nxt();
    redirect_vld = 1'b0;
    q0.push_back(32'h80); q0.push_back(32'h84);
    #1;
    chk("t4_last_wins", imem_addr, 32'h80);
    nxt(); nxt();
    fetch_en = 1'b0;
    #1;
    chk("t4_pc80", if_pc, 32'h80);
    nxt(); nxt(); #1;
    chk("t4_idle", 32'(if_valid), 0);
    chk("t4_drained", q0.size(), 0);
    // PC wrap from the top of the address space
    do_reset();
    rst_n = 1'b1; fetch_en1 = 1'b1; if_ready1 = 1'b1;
    q1.push_back(32'hFFFF_FFF8); q1.push_back(32'hFFFF_FFFC); q1.push_back(32'h0);
    #1;
    chk("t5_a0", imem_addr1, 32'hFFFF_FFF8);
    nxt(); #1;
    chk("t5_a1", imem_addr1, 32'hFFFF_FFFC);
    nxt(); #1;
    chk("t5_wrap", imem_addr1, 32'h0);
    chk("t5_p0", if_pc1, 32'hFFFF_FFF8);
    nxt();
    fetch_en1 = 1'b0;
    #1;
    chk("t5_p1", if_pc1, 32'hFFFF_FFFC);
    chk("t5_en_off", 32'(imem_en1), 0);
    nxt(); #1;
    chk("t5_p2", if_pc1, 32'h0);
    nxt(); #1;
    chk("t5_idle", 32'(if_valid1), 0);
    chk("t5_drained", q1.size(), 0);
    // fetch_en drop and mid-stream reset
    do_reset();
    rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
    q0.push_back(32'h0); q0.push_back(32'h4);
    nxt(); nxt();
    fetch_en = 1'b0;
    #1;
    chk("t6_en_off", 32'(imem_en), 0);
    chk("t6_pc0", if_pc, 32'h0);
    nxt(); #1;
    chk("t6_inflight_v", 32'(if_valid), 1);
    chk("t6_inflight_pc", if_pc, 32'h4);
    nxt(); #1;
    chk("t6_stopped_v", 32'(if_valid), 0);
    chk("t6_stopped_en", 32'(imem_en), 0);
    nxt();
    fetch_en = 1'b1;
    q0.push_back(32'h8);
    #1;
    chk("t6_hold_pc", imem_addr, 32'h8);
    nxt(); nxt(); nxt();
    rst_n = 1'b0;
    nxt();
    #1;
    chk("t6_rst_v", 32'(if_valid), 0);
    rst_n = 1'b1;
    q0.push_back(32'h0);
    #1;
    chk("t6_rst_en", 32'(imem_en), 1);
    chk("t6_rst_addr", imem_addr, 32'h0);
    nxt();
    fetch_en = 1'b0;
    nxt(); nxt(); #1;
    chk("t6_idle", 32'(if_valid), 0);
    chk("t6_drained", q0.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
